// File: rtl/uart_dbg_master_if.sv
// Native memory bus between the UART debug bridge (initiator) and the system bus.
// Request fields are held stable while mem_valid is high, until mem_ready is returned.
interface uart_dbg_master_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/uart_dbg_master.sv
// UART (8N1) command bridge to a valid/ready bus: W/R word access, H/G CPU hold control.
// Latency: bus request the clock after the last payload byte; waits on mem_ready unless timed out.
// Backpressure: bytes arriving in BUS/RESP are dropped; optional timeouts under UART_DBG_TIMEOUT_EN.
module uart_dbg_master #(
    parameter int CLK_DIV       = 5208,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ser_rx,
    output logic              ser_tx,
    uart_dbg_master_if.master bus,
    output logic              cpu_hold,
    output logic              busy
);
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [1:0]  RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    localparam logic [2:0]  C_IDLE = 3'd0, C_ADDR = 3'd1, C_DATA = 3'd2, C_BUS = 3'd3, C_RESP = 3'd4;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]  rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_strobe, rx_ferr;

    logic        tx_busy_q, tx_busy_d, ser_tx_q, ser_tx_d, tx_start, tx_done;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;

    logic [2:0]  st_q, st_d, resp_left_q, resp_left_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_wr_q, is_wr_d, cpu_hold_q, cpu_hold_d, mem_valid_q, mem_valid_d;
    logic [31:0] sh_q, sh_d, sh_next, resp_q, resp_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        gap_to, bus_to;

    // Receiver: start bit re-checked at mid-bit, then one sample per bit period.
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q + 16'd1;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_strobe = 1'b0;
        rx_ferr   = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d = '0;
                rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (rx_cnt_q == DIV_M1) begin
                rx_st_d   = RX_IDLE;
                rx_strobe = rx_s2_q;
                rx_ferr   = !rx_s2_q;
            end
        endcase
    end

    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_sh_d   = tx_sh_q;
        tx_bit_d  = tx_bit_q;
        tx_cnt_d  = tx_cnt_q;
        ser_tx_d  = ser_tx_q;
        tx_done   = 1'b0;
        if (tx_busy_q) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_done   = 1'b1;
                end else begin
                    ser_tx_d = tx_sh_q[0];
                    tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                    tx_bit_d = tx_bit_q + 4'd1;
                end
            end
        end else if (tx_start) begin
            tx_busy_d = 1'b1;
            tx_sh_d   = {1'b1, resp_q[7:0]};
            ser_tx_d  = 1'b0;
            tx_cnt_d  = '0;
            tx_bit_d  = '0;
        end
    end

    assign sh_next = {rx_sh_q, sh_q[31:8]};

    always_comb begin
        st_d        = st_q;
        resp_left_d = resp_left_q;
        resp_d      = resp_q;
        byte_cnt_d  = byte_cnt_q;
        is_wr_d     = is_wr_q;
        cpu_hold_d  = cpu_hold_q;
        mem_valid_d = mem_valid_q;
        sh_d        = sh_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        tx_start    = 1'b0;
        case (st_q)
            C_IDLE: if (rx_strobe) begin
                st_d        = C_RESP;
                resp_left_d = 3'd1;
                resp_d      = 32'h15;
                byte_cnt_d  = '0;
                case (rx_sh_q)
                    8'h57:   begin st_d = C_ADDR; is_wr_d = 1'b1; end
                    8'h52:   begin st_d = C_ADDR; is_wr_d = 1'b0; end
                    8'h48:   begin cpu_hold_d = 1'b1; resp_d = 32'h06; end
                    8'h47:   begin cpu_hold_d = 1'b0; resp_d = 32'h06; end
                    default: ;
                endcase
            end
            C_ADDR, C_DATA: begin
                if (rx_ferr) begin
                    st_d = C_IDLE;
                end else if (rx_strobe) begin
                    sh_d       = sh_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (st_q == C_ADDR) begin
                            mem_addr_d  = {sh_next[31:2], 2'b00};
                            mem_wstrb_d = is_wr_q ? 4'hF : 4'h0;
                            st_d        = is_wr_q ? C_DATA : C_BUS;
                            mem_valid_d = !is_wr_q;
                        end else begin
                            mem_wdata_d = sh_next;
                            st_d        = C_BUS;
                            mem_valid_d = 1'b1;
                        end
                    end
                end else if (gap_to) begin
                    st_d        = C_RESP;
                    resp_left_d = 3'd1;
                    resp_d      = 32'h15;
                end
            end
            C_BUS: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    st_d        = C_RESP;
                    resp_left_d = is_wr_q ? 3'd1 : 3'd4;
                    resp_d      = is_wr_q ? 32'h06 : bus.mem_rdata;
                end else if (bus_to) begin
                    mem_valid_d = 1'b0;
                    st_d        = C_RESP;
                    resp_left_d = 3'd1;
                    resp_d      = 32'h15;
                end
            end
            default: begin
                if (tx_done && resp_left_q == 3'd0) begin
                    st_d = C_IDLE;
                end else if (!tx_busy_q && resp_left_q != 3'd0) begin
                    tx_start    = 1'b1;
                    resp_d      = resp_q >> 8;
                    resp_left_d = resp_left_q - 3'd1;
                end
            end
        endcase
    end

`ifdef UART_DBG_TIMEOUT_EN
    localparam logic [23:0] GAP_LIM = 24'(16 * CLK_DIV * 10);
    logic [23:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] bus_cnt_q, bus_cnt_d;

    always_comb begin
        gap_cnt_d = '0;
        bus_cnt_d = '0;
        if ((st_q == C_ADDR || st_q == C_DATA) && !rx_strobe)
            gap_cnt_d = (gap_cnt_q == 24'hFF_FFFF) ? gap_cnt_q : gap_cnt_q + 24'd1;
        if (st_q == C_BUS) bus_cnt_d = bus_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_cnt_q <= '0;
            bus_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
            bus_cnt_q <= bus_cnt_d;
        end
    end

    assign gap_to = (gap_cnt_q >= GAP_LIM);
    assign bus_to = (bus_cnt_q == 16'hFFFF);
`else
    assign gap_to = 1'b0;
    assign bus_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
            rx_st_q <= RX_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_sh_q <= '0;
            tx_busy_q <= 1'b0;  ser_tx_q <= 1'b1;  tx_sh_q <= '1;  tx_bit_q <= '0;  tx_cnt_q <= '0;
            st_q <= C_IDLE;  resp_left_q <= '0;  resp_q <= '0;  byte_cnt_q <= '0;  is_wr_q <= 1'b0;
            cpu_hold_q <= HOLD_ON_RESET;  mem_valid_q <= 1'b0;  sh_q <= '0;
            mem_addr_q <= '0;  mem_wdata_q <= '0;  mem_wstrb_q <= '0;
        end else begin
            rx_s1_q <= ser_rx;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_s2_q;
            rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;
            tx_busy_q <= tx_busy_d;  ser_tx_q <= ser_tx_d;  tx_sh_q <= tx_sh_d;
            tx_bit_q <= tx_bit_d;  tx_cnt_q <= tx_cnt_d;
            st_q <= st_d;  resp_left_q <= resp_left_d;  resp_q <= resp_d;
            byte_cnt_q <= byte_cnt_d;  is_wr_q <= is_wr_d;
            cpu_hold_q <= cpu_hold_d;  mem_valid_q <= mem_valid_d;  sh_q <= sh_d;
            mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;  mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign ser_tx        = ser_tx_q;
    assign cpu_hold      = cpu_hold_q;
    assign busy          = (st_q != C_IDLE);
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_uart_dbg_master.sv
// Bench for uart_dbg_master at CLK_DIV=16: directed command table, corner sequences, random commands.
module tb_uart_dbg_master;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic resetn, ser_rx, ser_tx, cpu_hold, busy;
    uart_dbg_master_if bus_if();

    uart_dbg_master #(.CLK_DIV(DIV), .HOLD_ON_RESET(1'b1)) dut (
        .clk(clk), .resetn(resetn), .ser_rx(ser_rx), .ser_tx(ser_tx),
        .bus(bus_if), .cpu_hold(cpu_hold), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0]  host_q[$];
    int          tx_frame_bad = 0;
    int          vrise = 0, stab_err = 0, vcnt = 0, resp_lat = 2;
    bit          spur = 1'b0, prev_v = 1'b0;
    logic [31:0] rd_value = '0, cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    bit          model_hold;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr, wdata, rdata;
        int          n;
        logic [31:0] resp;
        bit          hold;
        int          txn;
        logic [31:0] eaddr, ewdata;
        logic [3:0]  ewstrb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Host-side receiver: samples mid-bit on the falling clock edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge ser_tx);
            repeat (DIV / 2) @(negedge clk);
            if (ser_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = ser_tx;
                end
                repeat (DIV) @(negedge clk);
                if (ser_tx) host_q.push_back(b);
                else tx_frame_bad++;
            end
        end
    end

    // Bus responder: answers resp_lat cycles after mem_valid rises, checks request stability.
    initial begin
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus_if.mem_ready = spur;
            if (bus_if.mem_valid) begin
                if (!prev_v) begin
                    vrise++;
                    vcnt      = 0;
                    cap_addr  = bus_if.mem_addr;
                    cap_wdata = bus_if.mem_wdata;
                    cap_wstrb = bus_if.mem_wstrb;
                end
                if (vcnt == resp_lat) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_rdata = rd_value;
                    if (bus_if.mem_addr !== cap_addr || bus_if.mem_wdata !== cap_wdata ||
                        bus_if.mem_wstrb !== cap_wstrb) stab_err++;
                end
                vcnt++;
            end
            prev_v = bus_if.mem_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        ser_rx = !bad_stop;
        repeat (DIV) @(negedge clk);
        if (bad_stop) begin
            ser_rx = 1'b1;
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        send_byte(c, 1'b0);
        if (c == 8'h57 || c == 8'h52)
            for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b0);
        if (c == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] got;
        int t;
        host_q.delete();
        vrise = 0;
        stab_err = 0;
        rd_value = v.rdata;
        send_frame(v.cmd, v.addr, v.wdata);
        t = 0;
        while (busy && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("busy_done", 32'(busy), 32'd0);
        chk("resp_count", host_q.size(), v.n);
        got = '0;
        foreach (host_q[i]) if (i < 4) got[8*i +: 8] = host_q[i];
        chk("resp_bytes", got, v.resp);
        chk("cpu_hold", 32'(cpu_hold), 32'(v.hold));
        chk("txn_count", vrise, v.txn);
        if (v.txn > 0) begin
            chk("mem_addr", cap_addr, v.eaddr);
            chk("mem_wstrb", 32'(cap_wstrb), 32'(v.ewstrb));
            chk("req_stable", stab_err, 0);
            if (v.cmd == 8'h57) chk("mem_wdata", cap_wdata, v.ewdata);
        end
    endtask

    // Reference: expected bus access and reply for one command, from the command rules.
    function automatic vec_t model(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] rd, input bit hold_in);
        vec_t v;
        v.cmd = c;  v.addr = a;  v.wdata = d;  v.rdata = rd;
        v.hold = hold_in;  v.txn = 0;  v.n = 1;  v.resp = 32'h15;
        v.eaddr = a & 32'hFFFF_FFFC;  v.ewdata = d;  v.ewstrb = 4'h0;
        case (c)
            8'h57: begin v.txn = 1; v.ewstrb = 4'hF; v.resp = 32'h06; end
            8'h52: begin v.txn = 1; v.n = 4; v.resp = rd; end
            8'h48: begin v.hold = 1'b1; v.resp = 32'h06; end
            8'h47: begin v.hold = 1'b0; v.resp = 32'h06; end
            default: ;
        endcase
        return v;
    endfunction

    vec_t vt[6];

    initial begin
        int t;
        vec_t v;
        logic [7:0] c;
        vt[0] = '{8'h57, 32'h10, 32'hDEADBEEF, 32'h0, 1, 32'h06, 1'b1, 1, 32'h10, 32'hDEADBEEF, 4'hF};
        vt[1] = '{8'h52, 32'h13, 32'h0, 32'h12345678, 4, 32'h12345678, 1'b1, 1, 32'h10, 32'h0, 4'h0};
        vt[2] = '{8'h47, 32'h0, 32'h0, 32'h0, 1, 32'h06, 1'b0, 0, 32'h0, 32'h0, 4'h0};
        vt[3] = '{8'h48, 32'h0, 32'h0, 32'h0, 1, 32'h06, 1'b1, 0, 32'h0, 32'h0, 4'h0};
        vt[4] = '{8'h41, 32'h0, 32'h0, 32'h0, 1, 32'h15, 1'b1, 0, 32'h0, 32'h0, 4'h0};
        vt[5] = '{8'h52, 32'h0, 32'h0, 32'h0, 4, 32'h00000000, 1'b1, 1, 32'h0, 32'h0, 4'h0};

        resetn = 1'b0;
        ser_rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // mem_ready while no request is outstanding must not start anything
        vrise = 0;
        spur = 1'b1;
        repeat (6) @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spurious_ready_valid", vrise, 0);
        chk("spurious_ready_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Framing error on the third address byte aborts the command silently
        host_q.delete();
        vrise = 0;
        send_byte(8'h57, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        repeat (200) @(negedge clk);
        chk("ferr_busy", 32'(busy), 32'd0);
        chk("ferr_no_reply", host_q.size(), 0);
        chk("ferr_no_txn", vrise, 0);
        run_vec(model(8'h48, 32'h0, 32'h0, 32'h0, 1'b1));

        // Reset while a write is outstanding
        resp_lat = 100000;
        send_frame(8'h57, 32'h0000_0040, 32'hCAFE_F00D);
        t = 0;
        while (!bus_if.mem_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("valid_before_reset", 32'(bus_if.mem_valid), 32'd1);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus_if.mem_valid), 32'd0);
        chk("async_rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        resp_lat = 2;
        repeat (4) @(negedge clk);
        run_vec(model(8'h47, 32'h0, 32'h0, 32'h0, 1'b1));

        model_hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 4))
                0: c = 8'h57;
                1: c = 8'h52;
                2: c = 8'h48;
                3: c = 8'h47;
                default: begin
                    c = 8'($urandom_range(0, 255));
                    if (c == 8'h57 || c == 8'h52 || c == 8'h48 || c == 8'h47) c = 8'h00;
                end
            endcase
            resp_lat = $urandom_range(0, 5);
            v = model(c, $urandom, $urandom, $urandom, model_hold);
            run_vec(v);
            model_hold = v.hold;
        end

        chk("tx_stop_bits", tx_frame_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
